// File: rtl/aftab_mux_nto1_reg.sv
`default_nettype none
// ============================================================================
// Module  : aftab_mux_nto1_reg
// Brief   : Registered N-to-1 selector with valid/ready output and skid buffer
// Revision: 1.0 - initial release
// ============================================================================
module aftab_mux_nto1_reg #(
    parameter  int SIZE   = 33,
    parameter  int INPUTS = 4,
    localparam int SELW   = (INPUTS > 1) ? $clog2(INPUTS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INPUTS*SIZE-1:0] data_in,
    input  logic [SELW-1:0]        sel,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [SIZE-1:0]        result,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   sel_err,
    input  logic                   clr_err
);

    // State bits are {out_valid, skid_valid}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_t;

    localparam logic [SELW:0] c_inputs = INPUTS[SELW:0];

    state_t            r_state;
    state_t            w_next;
    logic [SIZE-1:0]   r_result;
    logic [SIZE-1:0]   r_skid;
    logic              r_sel_err;
    logic [SIZE-1:0]   w_sel_word;
    logic              w_sel_bad;
    logic              w_accept;
    logic              w_xfer;
    logic              w_load_main;
    logic              w_load_skid;
    logic              w_main_from_skid;

    assign in_ready  = ~r_state[0];
    assign out_valid = r_state[1];
    assign result    = r_result;
    assign sel_err   = r_sel_err;

    assign w_accept  = in_valid & in_ready;
    assign w_xfer    = out_valid & out_ready;
    assign w_sel_bad = ({1'b0, sel} >= c_inputs);

    // Out-of-range selects match no input and yield an all-zero word.
    always_comb begin
        w_sel_word = '0;
        for (int k = 0; k < INPUTS; k++) begin
            if (sel == SELW'(k)) begin
                w_sel_word = data_in[k*SIZE +: SIZE];
            end
        end
    end

    always_comb begin
        w_next           = r_state;
        w_load_main      = 1'b0;
        w_load_skid      = 1'b0;
        w_main_from_skid = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_next      = ONE;
                    w_load_main = 1'b1;
                end
            end
            ONE: begin
                if (w_accept && !w_xfer) begin
                    w_next      = FULL;
                    w_load_skid = 1'b1;
                end else if (w_accept && w_xfer) begin
                    w_load_main = 1'b1;
                end else if (w_xfer) begin
                    w_next = EMPTY;
                end
            end
            FULL: begin
                if (w_xfer) begin
                    w_next           = ONE;
                    w_main_from_skid = 1'b1;
                end
            end
            default: w_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_result  <= '0;
            r_skid    <= '0;
            r_sel_err <= 1'b0;
        end else begin
            if (w_load_main) begin
                r_result <= w_sel_word;
            end else if (w_main_from_skid) begin
                r_result <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_sel_word;
            end
            // A new error takes priority over a clear in the same cycle.
            if (w_accept && w_sel_bad) begin
                r_sel_err <= 1'b1;
            end else if (clr_err) begin
                r_sel_err <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/aftab_mux_nto1_reg.md
# aftab_mux_nto1_reg

Parametrised, registered N-to-1 data selector for the AFTAB datapath. It replaces fixed two-input combinational selection wherever a selected operand must cross a pipeline boundary. The selected word passes through a one-cycle output register with a valid/ready handshake and a one-entry skid buffer, so back-pressure never drops or duplicates data. Out-of-range selects are detected and reported through a sticky error flag.

## Interface
Parameters:
- SIZE, 33, data word width in bits (≥1)
- INPUTS, 4, number of selectable inputs (2..16)
- SELW, $clog2(INPUTS) (minimum 1), select width; derived, never overridden

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset; asserting low clears all state immediately
- data_in  input  INPUTS*SIZE  flattened inputs; input k occupies bits [k*SIZE +: SIZE]
- sel  input  SELW  binary select, sampled with data_in on an accepted transfer
- in_valid  input  1  upstream presents data_in/sel
- in_ready  output  1  block can accept a word this cycle
- result  output  SIZE  selected word, registered
- out_valid  output  1  result holds a valid word
- out_ready  input  1  downstream consumes result this cycle
- sel_err  output  1  sticky flag: an accepted transfer had sel ≥ INPUTS
- clr_err  input  1  synchronous clear of sel_err

## Operation
- Input accept: in_valid && in_ready. Output transfer: out_valid && out_ready.
- Selected word: data_in[sel*SIZE +: SIZE] when sel < INPUTS. When sel ≥ INPUTS, the selected word is all-zero; it is still transferred.
- Storage:
  - Main register: result/out_valid.
  - Skid register: skid_data/skid_valid.
- in_ready = !skid_valid. It is a registered signal with no combinational path from out_ready.
- State, encoded by (out_valid, skid_valid):
  - EMPTY (0,0): on accept, load main and go to ONE.
  - ONE (1,0):
    - Accept with no transfer: load skid and go to FULL.
    - Accept with transfer: load main and stay in ONE.
    - Transfer with no accept: go to EMPTY.
    - Neither: hold.
  - FULL (1,1): in_ready = 0.
    - On transfer: main ← skid, skid_valid ← 0, go to ONE.
    - Otherwise hold.
  - The state (0,1) is illegal and unreachable.
- Ordering is strict FIFO; no word is lost or duplicated.
- result is held stable while out_valid && !out_ready.
- sel_err:
  - Set on any accept with sel ≥ INPUTS.
  - Cleared by clr_err. If set and clear occur in the same cycle, set wins.
- When INPUTS is a power of two, sel_err can never set. The logic is still present.

## Timing
- Reset values: result = 0, out_valid = 0, in_ready = 1 (skid_valid = 0), sel_err = 0.
- Reset takes effect asynchronously. Deassertion is synchronous to clk at the system level.
- Reset mid-transfer discards both stored words. in_ready returns to 1 in the first cycle after reset.
- Latency: a word accepted at edge t appears on result with out_valid = 1 after edge t, i.e. 1 cycle.
- Throughput: 1 word/cycle while out_ready stays high.
- Stall behaviour:
  - The first stall cycle still accepts one word into the skid register.
  - in_ready drops after that edge.
  - in_ready rises again the cycle after the transfer that drains the skid.
- sel_err rises the cycle after the offending accept. It is independent of whether that word has been consumed.
- Accept and transfer on the same edge in ONE: the new word replaces the consumed one with no bubble.

## Test plan
- Reset/basic (SIZE=33, INPUTS=4):
  - After reset: out_valid = 0, in_ready = 1, sel_err = 0.
  - Drive in_valid = 1, sel = 2, input2 = 33'h1_2345_6789, out_ready = 1 → result = 33'h1_2345_6789, out_valid = 1 one cycle later.
- Streaming: sel cycles through 0,1,2,3 on inputs 0xA, 0xB, 0xC, 0xD with out_ready = 1 → result sequence A, B, C, D on consecutive cycles, with no bubbles.
- Back-pressure:
  - Hold out_ready = 0 and present words W1, W2, W3 → W1 in main, W2 in skid, in_ready = 0, W3 held upstream.
  - Release out_ready → outputs W1, W2, W3 in order, each exactly once.
- Select error (INPUTS=3, SELW=2): accept with sel = 3 → result = 0 and sel_err = 1 the next cycle. sel_err stays 1 until clr_err is pulsed. A simultaneous bad select during clr_err leaves sel_err = 1.
- Reset mid-operation: in FULL state, drive rst low for half a cycle → out_valid, skid_valid and sel_err are 0 immediately, and in_ready = 1.
- Random soak: random in_valid/out_ready over 10k cycles against a scoreboard model → zero mismatches, no lost or duplicated words, and state (0,1) never reached.
